// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } arb_state_e;

  localparam int unsigned PORT_CORE = 0;
  localparam int unsigned PORT_HOST = 1;

  localparam int unsigned DEF_DATA_W  = 64;
  localparam int unsigned DEF_ADDR_W  = 64;
  localparam int unsigned DEF_IDX_W   = 10;
  localparam int unsigned DEF_MEM_LAT = 1;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 7.
  localparam int unsigned LAT_CNT_W = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select with next-pointer computation.
// The pointer flips away from the winner at each grant; a held lock pins it to the owner.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  input  logic       grant_en,
  input  logic       resp_en,
  input  logic       owner,
  input  logic       lock_hold,
  output logic       win,
  output logic       ptr_nxt
);

  // Winner: sole requester, or the pointed-to port on contention.
  always_comb begin
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = rr_ptr;
      default: win = 1'b0;
    endcase
  end

  // Pointer update: grant and response never happen in the same cycle.
  always_comb begin
    ptr_nxt = rr_ptr;
    if (grant_en) begin
      ptr_nxt = ~win;
    end else if (resp_en && lock_hold) begin
      ptr_nxt = owner;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core (port 0)
// and the host/loader (port 1). One access in flight; fixed memory latency.
// Optional macro DMEM_ARB_LOCK_EN adds lock_i[1:0] for burst ownership.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned IDX_W   = DEF_IDX_W,
  parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
`ifdef DMEM_ARB_LOCK_EN
  input  logic [1:0]        lock_i,
`endif
  output logic [1:0]        gnt_o,
  output logic [1:0]        rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [IDX_W-1:0]  mem_idx_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_e           state_q;
  logic                 rr_ptr_q;
  logic [LAT_CNT_W-1:0] lat_cnt_q;
  logic                 owner_q;
  logic                 we_q;
  logic [1:0]           rvalid_q;
  logic [DATA_W-1:0]    rdata_q;
  logic                 busy_q;

  logic                 arb_en;
  logic                 resp_en;
  logic                 win;
  logic                 ptr_nxt;
  logic                 lock_hold;
  logic [ADDR_W-1:0]    addr_sel;
  logic                 unused_addr_bits;

  // Gating with rst_n keeps every output low while reset is held.
  assign arb_en  = rst_n && (state_q == StIdle) && (req_i != 2'b00);
  assign resp_en = (state_q == StResp);

`ifdef DMEM_ARB_LOCK_EN
  assign lock_hold = lock_i[owner_q];
`else
  assign lock_hold = 1'b0;
`endif

  rr_arb2 u_rr_arb2 (
    .req       (req_i),
    .rr_ptr    (rr_ptr_q),
    .grant_en  (arb_en),
    .resp_en   (resp_en),
    .owner     (owner_q),
    .lock_hold (lock_hold),
    .win       (win),
    .ptr_nxt   (ptr_nxt)
  );

  assign addr_sel = (win == 1'(PORT_HOST)) ? addr1_i : addr0_i;

  // Doubleword access: byte offset and bits above the array alias away.
  assign unused_addr_bits = ^{addr_sel[ADDR_W-1:IDX_W+3], addr_sel[2:0]};

  // Grant-cycle memory command, driven straight from the winning requester.
  always_comb begin
    gnt_o       = 2'b00;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_idx_o   = '0;
    mem_wdata_o = '0;
    if (arb_en) begin
      gnt_o[win]  = 1'b1;
      mem_en_o    = 1'b1;
      mem_we_o    = we_i[win];
      mem_idx_o   = addr_sel[IDX_W+2:3];
      mem_wdata_o = (win == 1'(PORT_HOST)) ? wdata1_i : wdata0_i;
    end
  end

  // Access sequencer. WAIT always runs MEM_LAT cycles so read data is sampled exactly
  // MEM_LAT cycles after the enable, including MEM_LAT == 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rr_ptr_q  <= 1'b0;
      lat_cnt_q <= '0;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      rvalid_q  <= 2'b00;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      rr_ptr_q <= ptr_nxt;
      rvalid_q <= 2'b00;
      case (state_q)
        StIdle: begin
          if (arb_en) begin
            owner_q   <= win;
            we_q      <= we_i[win];
            lat_cnt_q <= LAT_CNT_W'(MEM_LAT - 1);
            busy_q    <= 1'b1;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (lat_cnt_q == '0) begin
            rvalid_q[owner_q] <= 1'b1;
            if (!we_q) begin
              rdata_q <= mem_rdata_i;
            end
            state_q <= StResp;
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_CNT_W'(1);
          end
        end
        StResp: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at MEM_LAT=1 with a memory model,
// one at MEM_LAT=3 fed by a tagged read pipeline.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // MEM_LAT = 1 instance
  logic [1:0]  req, we;
  logic [63:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  gnt, rvalid;
  logic [63:0] rdata, mem_wdata, mem_rdata;
  logic        busy, mem_en, mem_we;
  logic [9:0]  mem_idx;
  logic [63:0] mem [1024];
`ifdef DMEM_ARB_LOCK_EN
  logic [1:0]  lock;
`endif

  // MEM_LAT = 3 instance
  logic [1:0]  req3;
  logic [63:0] addr3;
  logic [1:0]  gnt3, rvalid3;
  logic [63:0] rdata3, wdata3o, p1, p2, p3;
  logic        busy3, en3, we3o;
  logic [9:0]  idx3;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.DATA_W(64), .ADDR_W(64), .IDX_W(10), .MEM_LAT(1)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .we_i        (we),
    .addr0_i     (addr0),
    .addr1_i     (addr1),
    .wdata0_i    (wdata0),
    .wdata1_i    (wdata1),
`ifdef DMEM_ARB_LOCK_EN
    .lock_i      (lock),
`endif
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .busy_o      (busy),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_idx_o   (mem_idx),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  dmem_arbiter #(.DATA_W(64), .ADDR_W(64), .IDX_W(10), .MEM_LAT(3)) u_dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req3),
    .we_i        (2'b00),
    .addr0_i     (addr3),
    .addr1_i     (64'h0),
    .wdata0_i    (64'h0),
    .wdata1_i    (64'h0),
`ifdef DMEM_ARB_LOCK_EN
    .lock_i      (2'b00),
`endif
    .gnt_o       (gnt3),
    .rvalid_o    (rvalid3),
    .rdata_o     (rdata3),
    .busy_o      (busy3),
    .mem_en_o    (en3),
    .mem_we_o    (we3o),
    .mem_idx_o   (idx3),
    .mem_wdata_o (wdata3o),
    .mem_rdata_i (p3)
  );

  function automatic logic [63:0] pat(input logic [9:0] i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  // One-cycle synchronous memory
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_idx] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_idx];
  end

  // Three-cycle read pipeline returning a tag of the index
  always @(posedge clk) begin
    p1 <= en3 ? pat(idx3) : 64'h0;
    p2 <= p1;
    p3 <= p2;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] alias_addr [2];
    logic [1:0]  alt_exp [3];
    alias_addr[0] = 64'h107;
    alias_addr[1] = 64'h2100;
    alt_exp[0] = 2'b01;
    alt_exp[1] = 2'b10;
    alt_exp[2] = 2'b01;

    rst_n = 1'b0; req = 2'b11; we = 2'b00;
    addr0 = 64'h0; addr1 = 64'h0; wdata0 = 64'h0; wdata1 = 64'h0;
    req3 = 2'b00; addr3 = 64'h0;
    p1 = 64'h0; p2 = 64'h0; p3 = 64'h0; mem_rdata = 64'h0;
`ifdef DMEM_ARB_LOCK_EN
    lock = 2'b00;
`endif

    // Reset state, requests high but gated
    cyc();
    check_eq("rst_gnt", gnt, 2'b00);
    check_eq("rst_mem_en", mem_en, 1'b0);
    check_eq("rst_rvalid", rvalid, 2'b00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_rdata", rdata, 64'h0);
    check_eq("rst_busy3", busy3, 1'b0);
    cyc();
    rst_n = 1'b1; req = 2'b00;

    // Host write to 0x100
    cyc();
    req = 2'b10; we = 2'b10; addr1 = 64'h100; wdata1 = 64'h1234567890ABCDEF;
    #1;
    check_eq("hw_gnt", gnt, 2'b10);
    check_eq("hw_en", mem_en, 1'b1);
    check_eq("hw_we", mem_we, 1'b1);
    check_eq("hw_idx", mem_idx, 10'd32);
    check_eq("hw_wdata", mem_wdata, 64'h1234567890ABCDEF);
    cyc();
    req = 2'b00; we = 2'b00;
    #1;
    check_eq("hw_wait_busy", busy, 1'b1);
    check_eq("hw_wait_en", mem_en, 1'b0);
    check_eq("hw_wait_rvalid", rvalid, 2'b00);
    cyc();
    check_eq("hw_rvalid", rvalid, 2'b10);
    check_eq("hw_rdata_hold", rdata, 64'h0);
    cyc();
    check_eq("hw_idle_busy", busy, 1'b0);
    check_eq("hw_idle_rvalid", rvalid, 2'b00);

    // Core readback of 0x100
    req = 2'b01; addr0 = 64'h100;
    #1;
    check_eq("cr_gnt", gnt, 2'b01);
    check_eq("cr_we", mem_we, 1'b0);
    check_eq("cr_idx", mem_idx, 10'd32);
    cyc();
    req = 2'b00;
    #1;
    check_eq("cr_wait_rvalid", rvalid, 2'b00);
    cyc();
    check_eq("cr_rvalid", rvalid, 2'b01);
    check_eq("cr_rdata", rdata, 64'h1234567890ABCDEF);

    // Address aliasing: low 3 bits and bits above the index ignored
    for (int i = 0; i < 2; i++) begin
      cyc();
      req = 2'b01; addr0 = alias_addr[i];
      #1;
      check_eq("alias_gnt", gnt, 2'b01);
      check_eq("alias_idx", mem_idx, 10'd32);
      cyc();
      req = 2'b00;
      cyc();
      check_eq("alias_rvalid", rvalid, 2'b01);
      check_eq("alias_rdata", rdata, 64'h1234567890ABCDEF);
    end

    // Withdrawal while busy is never granted
    cyc();
    check_eq("idle_nogrant", gnt, 2'b00);
    req = 2'b10; we = 2'b10; addr1 = 64'h200; wdata1 = 64'hAA;
    #1;
    check_eq("wd_gnt", gnt, 2'b10);
    cyc();
    req = 2'b01; we = 2'b00;
    cyc();
    check_eq("wd_rvalid", rvalid, 2'b10);
    check_eq("wd_resp_gnt", gnt, 2'b00);
    req = 2'b00;
    cyc();
    check_eq("wd_idle_gnt", gnt, 2'b00);
    check_eq("wd_idle_en", mem_en, 1'b0);

    // Fresh reset, then both request continuously: 01,10,01
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    cyc();
    req = 2'b11; addr0 = 64'h100; addr1 = 64'h200;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("alt_gnt", gnt, 64'(alt_exp[i]));
      cyc();
      cyc();
      check_eq("alt_rvalid", rvalid, 64'(alt_exp[i]));
      check_eq("alt_resp_gnt", gnt, 2'b00);
      cyc();
    end

    // Reset mid-access: grant goes to host (pointer at 1), then reset in WAIT
    check_eq("mid_gnt", gnt, 2'b10);
    cyc();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_gnt", gnt, 2'b00);
    check_eq("mid_rst_en", mem_en, 1'b0);
    check_eq("mid_rst_rvalid", rvalid, 2'b00);
    cyc();
    rst_n = 1'b1; req = 2'b00;
    cyc();
    check_eq("mid_no_rvalid_a", rvalid, 2'b00);
    cyc();
    check_eq("mid_no_rvalid_b", rvalid, 2'b00);
    check_eq("mid_idle_busy", busy, 1'b0);
    req = 2'b11;
    #1;
    check_eq("mid_regrant", gnt, 2'b01);
    cyc();
    req = 2'b00;
    cyc();
    cyc();

    // MEM_LAT = 3: busy 4 cycles, rvalid 4 cycles after grant, no enable in WAIT
    req3 = 2'b01; addr3 = 64'h18;
    #1;
    check_eq("l3_gnt", gnt3, 2'b01);
    check_eq("l3_idx", idx3, 10'd3);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      req3 = 2'b00;
      #1;
      check_eq("l3_busy", busy3, (k <= 4) ? 1'b1 : 1'b0);
      check_eq("l3_en", en3, 1'b0);
      check_eq("l3_rvalid", rvalid3, (k == 4) ? 2'b01 : 2'b00);
      if (k == 4) check_eq("l3_rdata", rdata3, pat(10'd3));
    end

`ifdef DMEM_ARB_LOCK_EN
    // Locked host burst holds off the core until the lock drops
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    cyc();
    req = 2'b10; we = 2'b10; lock = 2'b10; addr1 = 64'h8; wdata1 = 64'h1;
    #1;
    check_eq("lk_gnt1", gnt, 2'b10);
    cyc();
    req = 2'b11;
    cyc();
    check_eq("lk_rvalid1", rvalid, 2'b10);
    cyc();
    check_eq("lk_gnt2", gnt, 2'b10);
    cyc();
    cyc();
    check_eq("lk_rvalid2", rvalid, 2'b10);
    cyc();
    check_eq("lk_gnt3", gnt, 2'b10);
    cyc();
    lock = 2'b00;
    cyc();
    check_eq("lk_rvalid3", rvalid, 2'b10);
    cyc();
    check_eq("lk_core_gnt", gnt, 2'b01);
    req = 2'b00;
    cyc();
    cyc();
    check_eq("lk_core_rvalid", rvalid, 2'b01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
